// File: rtl/ysyx_24120013_idu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_24120013_idu_pipe
// Purpose  : One-entry RV instruction-decode pipeline stage. It decodes the
//            opcode, immediate and destination of the incoming instruction
//            and registers them together with the register-file operands
//            behind a valid/ready handshake. Full throughput is supported:
//            a new instruction can be taken in the same cycle the held one
//            is handed downstream.
// Ports    : clk, rst (async, active-high)
//            in_valid/in_ready/inst/in_pc  upstream handshake + instruction
//            flush                         synchronous kill of the stage
//            IDU_raddr1/2, rdata1/2        combinational register-file read
//            out_valid/out_ready           downstream handshake
//            IDU_src1/2, IDU_des, IDU_imm,
//            IDU_command, out_pc,
//            out_illegal                   registered decoded bundle
//            perf_cnt                      bundles accepted downstream
// Revision : 1.0  initial release
// ============================================================================
module ysyx_24120013_idu_pipe #(
  parameter int ADDR_WIDTH    = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int COMMAND_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              inst,
  input  logic [DATA_WIDTH-1:0]    in_pc,
  input  logic                     flush,
  output logic [ADDR_WIDTH-1:0]    IDU_raddr1,
  output logic [ADDR_WIDTH-1:0]    IDU_raddr2,
  input  logic [DATA_WIDTH-1:0]    rdata1,
  input  logic [DATA_WIDTH-1:0]    rdata2,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    IDU_src1,
  output logic [DATA_WIDTH-1:0]    IDU_src2,
  output logic [ADDR_WIDTH-1:0]    IDU_des,
  output logic [DATA_WIDTH-1:0]    IDU_imm,
  output logic [COMMAND_WIDTH-1:0] IDU_command,
  output logic [DATA_WIDTH-1:0]    out_pc,
  output logic                     out_illegal,
  output logic [31:0]              perf_cnt
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] c_OPC_OP     = 7'b0110011;
  localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] c_OPC_SYSTEM = 7'b1110011;

  state_t                   r_state;
  logic [DATA_WIDTH-1:0]    r_src1;
  logic [DATA_WIDTH-1:0]    r_src2;
  logic [ADDR_WIDTH-1:0]    r_des;
  logic [DATA_WIDTH-1:0]    r_imm;
  logic [COMMAND_WIDTH-1:0] r_cmd;
  logic [DATA_WIDTH-1:0]    r_pc;
  logic                     r_illegal;
  logic [31:0]              r_perf_cnt;

  logic [6:0]               w_opcode;
  logic [COMMAND_WIDTH-1:0] w_cmd;
  logic                     w_illegal;
  logic                     w_has_rd;
  logic signed [31:0]       w_imm32;
  logic [DATA_WIDTH-1:0]    w_imm_ext;
  logic                     w_accept;
  logic                     w_handoff;

  assign w_opcode   = inst[6:0];
  assign IDU_raddr1 = ADDR_WIDTH'(inst[19:15]);
  assign IDU_raddr2 = ADDR_WIDTH'(inst[24:20]);

  assign out_valid  = (r_state == ST_FULL);
  assign in_ready   = (!out_valid || out_ready) && !flush;
  assign w_accept   = in_valid && in_ready;
  // A bundle leaving during a flush cycle is killed, so it is not counted.
  assign w_handoff  = out_valid && out_ready && !flush;

  // Every immediate is built as a signed 32-bit value first; the signed
  // size cast then sign-extends it to DATA_WIDTH (no-op when 32).
  assign w_imm_ext  = DATA_WIDTH'(w_imm32);

  always_comb begin
    w_cmd     = '0;
    w_illegal = 1'b0;
    w_has_rd  = 1'b1;
    w_imm32   = '0;
    case (w_opcode)
      c_OPC_OP_IMM: begin
        w_cmd   = COMMAND_WIDTH'(1);
        w_imm32 = {{20{inst[31]}}, inst[31:20]};
      end
      c_OPC_OP: begin
        w_cmd   = COMMAND_WIDTH'(2);
      end
      c_OPC_LOAD: begin
        w_cmd   = COMMAND_WIDTH'(3);
        w_imm32 = {{20{inst[31]}}, inst[31:20]};
      end
      c_OPC_STORE: begin
        w_cmd    = COMMAND_WIDTH'(4);
        w_has_rd = 1'b0;
        w_imm32  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      c_OPC_BRANCH: begin
        w_cmd    = COMMAND_WIDTH'(5);
        w_has_rd = 1'b0;
        w_imm32  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      c_OPC_LUI: begin
        w_cmd   = COMMAND_WIDTH'(6);
        w_imm32 = {inst[31:12], 12'b0};
      end
      c_OPC_AUIPC: begin
        w_cmd   = COMMAND_WIDTH'(7);
        w_imm32 = {inst[31:12], 12'b0};
      end
      c_OPC_JAL: begin
        w_cmd   = COMMAND_WIDTH'(8);
        w_imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      c_OPC_JALR: begin
        w_cmd   = COMMAND_WIDTH'(9);
        w_imm32 = {{20{inst[31]}}, inst[31:20]};
      end
      c_OPC_SYSTEM: begin
        w_cmd   = COMMAND_WIDTH'(10);
        w_imm32 = {{20{inst[31]}}, inst[31:20]};
      end
      default: begin
        w_illegal = 1'b1;
        w_has_rd  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_EMPTY;
      r_src1     <= '0;
      r_src2     <= '0;
      r_des      <= '0;
      r_imm      <= '0;
      r_cmd      <= '0;
      r_pc       <= '0;
      r_illegal  <= 1'b0;
      r_perf_cnt <= '0;
    end else begin
      if (w_handoff) begin
        r_perf_cnt <= r_perf_cnt + 32'd1;
      end
      // in_ready already contains !flush, so flush dominates any accept.
      if (flush) begin
        r_state <= ST_EMPTY;
      end else if (w_accept) begin
        r_state   <= ST_FULL;
        r_src1    <= rdata1;
        r_src2    <= rdata2;
        r_des     <= w_has_rd ? ADDR_WIDTH'(inst[11:7]) : '0;
        r_imm     <= w_imm_ext;
        r_cmd     <= w_cmd;
        r_pc      <= in_pc;
        r_illegal <= w_illegal;
      end else if (out_ready) begin
        r_state <= ST_EMPTY;
      end
    end
  end

  assign IDU_src1    = r_src1;
  assign IDU_src2    = r_src2;
  assign IDU_des     = r_des;
  assign IDU_imm     = r_imm;
  assign IDU_command = r_cmd;
  assign out_pc      = r_pc;
  assign out_illegal = r_illegal;
  assign perf_cnt    = r_perf_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24120013_idu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_24120013_idu_pipe
// Purpose  : Self-checking bench for ysyx_24120013_idu_pipe. Expected bundles
//            are pushed into a scoreboard queue when an instruction is
//            accepted and compared while the stage presents them.
// Revision : 1.0  initial release
// ============================================================================
module tb_ysyx_24120013_idu_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inst;
  logic [31:0] in_pc;
  logic        flush;
  logic [4:0]  IDU_raddr1;
  logic [4:0]  IDU_raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] IDU_src1;
  logic [31:0] IDU_src2;
  logic [4:0]  IDU_des;
  logic [31:0] IDU_imm;
  logic [3:0]  IDU_command;
  logic [31:0] out_pc;
  logic        out_illegal;
  logic [31:0] perf_cnt;

  ysyx_24120013_idu_pipe #(
    .ADDR_WIDTH(5), .DATA_WIDTH(32), .COMMAND_WIDTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .inst(inst), .in_pc(in_pc),
    .flush(flush),
    .IDU_raddr1(IDU_raddr1), .IDU_raddr2(IDU_raddr2),
    .rdata1(rdata1), .rdata2(rdata2),
    .out_valid(out_valid), .out_ready(out_ready),
    .IDU_src1(IDU_src1), .IDU_src2(IDU_src2), .IDU_des(IDU_des),
    .IDU_imm(IDU_imm), .IDU_command(IDU_command), .out_pc(out_pc),
    .out_illegal(out_illegal), .perf_cnt(perf_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] src1;
    logic [31:0] src2;
    logic [4:0]  des;
    logic [31:0] imm;
    logic [3:0]  cmd;
    logic [31:0] pc;
    logic        illegal;
  } bundle_t;

  bundle_t     q[$];
  logic        m_full;
  logic [31:0] m_perf;
  int          n_cmp;
  int          n_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sx12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

  // Reference decode written directly from the instruction-format table.
  function automatic bundle_t model(input logic [31:0] ins, input logic [31:0] pc,
                                    input logic [31:0] r1, input logic [31:0] r2);
    bundle_t b;
    b.src1 = r1; b.src2 = r2; b.pc = pc; b.illegal = 1'b0;
    b.des = ins[11:7]; b.imm = '0;
    case (ins[6:0])
      7'b0010011: begin b.cmd = 4'd1;  b.imm = sx12(ins[31:20]); end
      7'b0110011: begin b.cmd = 4'd2; end
      7'b0000011: begin b.cmd = 4'd3;  b.imm = sx12(ins[31:20]); end
      7'b0100011: begin b.cmd = 4'd4;  b.imm = sx12({ins[31:25], ins[11:7]}); b.des = '0; end
      7'b1100011: begin
        b.cmd = 4'd5; b.des = '0;
        b.imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      7'b0110111: begin b.cmd = 4'd6;  b.imm = {ins[31:12], 12'h000}; end
      7'b0010111: begin b.cmd = 4'd7;  b.imm = {ins[31:12], 12'h000}; end
      7'b1101111: begin
        b.cmd = 4'd8;
        b.imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      7'b1100111: begin b.cmd = 4'd9;  b.imm = sx12(ins[31:20]); end
      7'b1110011: begin b.cmd = 4'd10; b.imm = sx12(ins[31:20]); end
      default:    begin b.cmd = 4'd0;  b.illegal = 1'b1; b.des = '0; end
    endcase
    return b;
  endfunction

  // Apply inputs just after a rising edge, then check everything at the
  // following falling edge.
  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic ordy, input logic fl);
    in_valid = v; inst = ins; in_pc = pc; rdata1 = r1; rdata2 = r2;
    out_ready = ordy; flush = fl;
    @(negedge clk);
    chk("in_ready", {63'd0, in_ready}, {63'd0, (!m_full || ordy) && !fl});
    chk("raddr1", {59'd0, IDU_raddr1}, {59'd0, ins[19:15]});
    chk("raddr2", {59'd0, IDU_raddr2}, {59'd0, ins[24:20]});
    chk("out_valid", {63'd0, out_valid}, {63'd0, m_full});
    chk("perf_cnt", {32'd0, perf_cnt}, {32'd0, m_perf});
    if (m_full) begin
      if (q.size() == 0) begin
        chk("scoreboard_empty", 64'd1, 64'd0);
      end else begin
        chk("src1", {32'd0, IDU_src1}, {32'd0, q[0].src1});
        chk("src2", {32'd0, IDU_src2}, {32'd0, q[0].src2});
        chk("des", {59'd0, IDU_des}, {59'd0, q[0].des});
        chk("imm", {32'd0, IDU_imm}, {32'd0, q[0].imm});
        chk("command", {60'd0, IDU_command}, {60'd0, q[0].cmd});
        chk("pc", {32'd0, out_pc}, {32'd0, q[0].pc});
        chk("illegal", {63'd0, out_illegal}, {63'd0, q[0].illegal});
      end
    end
  endtask

  task automatic tick();
    logic    acc;
    logic    ho;
    bundle_t b;
    acc = in_valid && (!m_full || out_ready) && !flush;
    ho  = m_full && out_ready && !flush;
    b   = model(inst, in_pc, rdata1, rdata2);
    @(posedge clk);
    if (ho) begin
      void'(q.pop_front());
      m_perf = m_perf + 32'd1;
    end
    if (flush) begin
      q.delete();
      m_full = 1'b0;
    end else if (acc) begin
      q.push_back(b);
      m_full = 1'b1;
    end else if (out_ready) begin
      m_full = 1'b0;
    end
    #1;
  endtask

  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic [31:0] r1, input logic [31:0] r2,
                      input logic ordy, input logic fl);
    drive(v, ins, pc, r1, r2, ordy, fl);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_err = 0; m_full = 1'b0; m_perf = '0;
    rst = 1'b1; in_valid = 1'b0; inst = '0; in_pc = '0; rdata1 = '0; rdata2 = '0;
    out_ready = 1'b0; flush = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_imm", {32'd0, IDU_imm}, 64'd0);
    chk("rst_perf", {32'd0, perf_cnt}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Test 1: addi x1,x2,-1
    drive(1'b1, 32'hFFF10093, 32'h1000, 32'd5, 32'd9, 1'b1, 1'b0);
    chk("t1_raddr1", {59'd0, IDU_raddr1}, 64'd2);
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("t1_cmd", {60'd0, IDU_command}, 64'd1);
    chk("t1_imm", {32'd0, IDU_imm}, 64'hFFFFFFFF);
    chk("t1_des", {59'd0, IDU_des}, 64'd1);
    chk("t1_src1", {32'd0, IDU_src1}, 64'd5);
    tick();

    // Test 2/3: format coverage, back-to-back
    step(1'b1, 32'hFE512E23, 32'h1004, 32'd11, 32'd12, 1'b1, 1'b0);
    drive(1'b1, 32'hFF9FF06F, 32'h1008, 32'd13, 32'd14, 1'b1, 1'b0);
    chk("t2_sw_cmd", {60'd0, IDU_command}, 64'd4);
    chk("t2_sw_imm", {32'd0, IDU_imm}, 64'hFFFFFFFC);
    chk("t2_sw_des", {59'd0, IDU_des}, 64'd0);
    tick();
    drive(1'b1, 32'h123451B7, 32'h100C, 32'd15, 32'd16, 1'b1, 1'b0);
    chk("t2_jal_cmd", {60'd0, IDU_command}, 64'd8);
    chk("t2_jal_imm", {32'd0, IDU_imm}, 64'hFFFFFFF8);
    tick();
    drive(1'b1, 32'h00000000, 32'h1010, 32'd17, 32'd18, 1'b1, 1'b0);
    chk("t3_lui_cmd", {60'd0, IDU_command}, 64'd6);
    chk("t3_lui_imm", {32'd0, IDU_imm}, 64'h12345000);
    chk("t3_lui_des", {59'd0, IDU_des}, 64'd3);
    tick();
    drive(1'b1, 32'h80A08463, 32'h1014, 32'd19, 32'd20, 1'b1, 1'b0);  // beq, negative offset
    chk("t3_ill_cmd", {60'd0, IDU_command}, 64'd0);
    chk("t3_ill_flag", {63'd0, out_illegal}, 64'd1);
    tick();
    step(1'b1, 32'h00C2A303, 32'h1018, 32'd21, 32'd22, 1'b1, 1'b0);   // lw
    step(1'b1, 32'h00B50533, 32'h101C, 32'd23, 32'd24, 1'b1, 1'b0);   // add
    step(1'b1, 32'hFFC08067, 32'h1020, 32'd25, 32'd26, 1'b1, 1'b0);   // jalr
    step(1'b1, 32'h00001297, 32'h1024, 32'd27, 32'd28, 1'b1, 1'b0);   // auipc
    step(1'b1, 32'h00100073, 32'h1028, 32'd29, 32'd30, 1'b1, 1'b0);   // ebreak
    step(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);

    // Test 4: backpressure for 3 cycles, then streaming
    step(1'b1, 32'h06400113, 32'h2000, 32'hAAAA, 32'hBBBB, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h00310193, 32'h2004, 32'hCCCC, 32'hDDDD, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'h00110113 + (i << 20), 32'h2008 + i * 4, i, i + 100, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);

    // Test 5: flush while FULL with a pending instruction
    step(1'b1, 32'h00500093, 32'h3000, 32'd1, 32'd2, 1'b1, 1'b0);
    step(1'b1, 32'h00600093, 32'h3004, 32'd3, 32'd4, 1'b1, 1'b1);
    step(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);

    // Test 6a: counter wrap from a preset value
    step(1'b1, 32'h00700093, 32'h4000, 32'd7, 32'd8, 1'b1, 1'b0);
    force dut.r_perf_cnt = 32'hFFFFFFFF;
    #1;
    release dut.r_perf_cnt;
    m_perf = 32'hFFFFFFFF;
    step(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("t6_wrap", {32'd0, perf_cnt}, 64'd0);
    tick();

    // Test 6b: asynchronous reset while FULL
    step(1'b1, 32'h00800093, 32'h5000, 32'd9, 32'd10, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("t6_rst_src1", {32'd0, IDU_src1}, 64'd0);
    chk("t6_rst_imm", {32'd0, IDU_imm}, 64'd0);
    chk("t6_rst_des", {59'd0, IDU_des}, 64'd0);
    chk("t6_rst_pc", {32'd0, out_pc}, 64'd0);
    chk("t6_rst_perf", {32'd0, perf_cnt}, 64'd0);
    #1;
    rst = 1'b0;
    q.delete(); m_full = 1'b0; m_perf = '0;
    tick();
    step(1'b1, 32'h00900093, 32'h6000, 32'd11, 32'd12, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ysyx_24120013_idu_pipe.md
YSYX_24120013_IDU_PIPE -- requirements
Module: ysyx_24120013_idu_pipe

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 5, register index width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32 (legal values 32 and 64), operand/immediate/PC width.
REQ-003 The block SHALL have parameter COMMAND_WIDTH, default 4 (minimum 4), command code width.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset, with ports as listed below:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  block can accept an instruction this cycle.
- inst  in  32  instruction word.
- in_pc  in  DATA_WIDTH  PC of inst.
- flush  in  1  synchronous pipeline kill.
- IDU_raddr1  out  ADDR_WIDTH  register-file read index 1 = inst[19:15], combinational.
- IDU_raddr2  out  ADDR_WIDTH  register-file read index 2 = inst[24:20], combinational.
- rdata1  in  DATA_WIDTH  register-file data for IDU_raddr1, same cycle.
- rdata2  in  DATA_WIDTH  register-file data for IDU_raddr2, same cycle.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  downstream accepts bundle.
- IDU_src1  out  DATA_WIDTH  registered rdata1.
- IDU_src2  out  DATA_WIDTH  registered rdata2.
- IDU_des  out  ADDR_WIDTH  registered inst[11:7].
- IDU_imm  out  DATA_WIDTH  registered sign-extended immediate.
- IDU_command  out  COMMAND_WIDTH  registered command code.
- out_pc  out  DATA_WIDTH  registered in_pc.
- out_illegal  out  1  registered illegal-opcode flag.
- perf_cnt  out  32  count of bundles accepted downstream.

Function
REQ-005 The block SHALL be a one-entry pipeline stage with states EMPTY (out_valid=0) and FULL (out_valid=1); latency is 1 cycle from input accept to out_valid.
REQ-006 in_ready SHALL equal (!out_valid || out_ready) && !flush, combinationally.
REQ-007 On accept (in_valid && in_ready), the stage SHALL capture the decoded bundle and enter or stay in FULL.
REQ-008 In FULL with out_ready=1 and no accept, the stage SHALL go to EMPTY; with a simultaneous accept, it SHALL stay FULL with the new bundle (full throughput, no bubble).
REQ-009 In FULL with out_ready=0, all bundle outputs SHALL hold stable.
REQ-010 flush=1 SHALL force EMPTY at the next edge and block any accept that cycle, overriding every other event; perf_cnt SHALL NOT count a bundle handed off in the flush cycle.
REQ-011 Opcode decode SHALL map to IDU_command as follows, with out_illegal=0 for every listed opcode:
- OP-IMM 0010011 -> 1; OP 0110011 -> 2; LOAD 0000011 -> 3; STORE 0100011 -> 4.
- BRANCH 1100011 -> 5; LUI 0110111 -> 6; AUIPC 0010111 -> 7.
- JAL 1101111 -> 8; JALR 1100111 -> 9; SYSTEM 1110011 -> 10.
- Any other opcode -> command 0, out_illegal=1.
REQ-012 Immediates SHALL be taken from inst by format, sign-extended from bit 31 to DATA_WIDTH:
- I (OP-IMM, LOAD, JALR, SYSTEM): inst[31:20].
- S: {inst[31:25],inst[11:7]}.
- B: {inst[31],inst[7],inst[30:25],inst[11:8],0}.
- U: {inst[31:12],12'b0}.
- J: {inst[31],inst[19:12],inst[20],inst[30:21],0}.
- OP and illegal: 0.
REQ-013 IDU_des SHALL be 0 for STORE, BRANCH and illegal instructions.
REQ-014 perf_cnt SHALL increment by 1 on each out_valid && out_ready edge and wrap from 0xFFFFFFFF to 0.

Reset
REQ-015 While rst=1 the stage SHALL be EMPTY, and IDU_src1, IDU_src2, IDU_imm, out_pc and perf_cnt SHALL be 0, with IDU_des=0, IDU_command=0 and out_illegal=0, asynchronously.
REQ-016 Reset asserted mid-operation SHALL discard the held bundle; the first accept SHALL be possible in the first cycle after rst deasserts.

Verification
REQ-017 Test 1: inst=0xFFF10093, rdata1=5, out_ready=1 -> next cycle out_valid=1, command=1, imm=0xFFFFFFFF, des=1, src1=5; IDU_raddr1=2 in the accept cycle.
REQ-018 Test 2: inst=0xFE512E23 (sw x5,-4(x2)) -> command=4, imm=0xFFFFFFFC, des=0; inst=0xFF9FF06F -> command=8, imm=0xFFFFFFF8.
REQ-019 Test 3: inst=0x123451B7 -> command=6, imm=0x12345000, des=3; inst=0x00000000 -> command=0, out_illegal=1.
REQ-020 Test 4: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable; then out_ready=1 -> back-to-back bundles with no bubble, perf_cnt +1 per handoff.
REQ-021 Test 5: flush=1 while FULL and in_valid=1 -> next cycle out_valid=0, nothing captured, perf_cnt unchanged.
REQ-022 Test 6: rst pulse while FULL -> out_valid=0 and all outputs 0 immediately; perf_cnt preset to 0xFFFFFFFF via stimulus then one handoff -> perf_cnt=0.
